// File: rtl/seg_scan_driver.sv
// Six-digit seven-segment scan driver with a double-buffered value applied at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_LEADING_ZERO_EN.
module seg_scan_driver #(
  parameter int SCAN_CNT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] din,
  input  logic [5:0]  dp_in,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CNT - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [23:0]   disp_dat;
  logic [5:0]    disp_dp;
  logic [23:0]   shd_dat;
  logic [5:0]    shd_dp;
  logic          pend;

  logic          last;
  logic          xfer;
  logic          swap;
  logic [2:0]    idx_nxt;
  logic [23:0]   disp_dat_nxt;
  logic [5:0]    disp_dp_nxt;
  logic [3:0]    nib;
  logic          blank;
  logic [5:0]    sel_nxt;
  logic [7:0]    seg_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign last       = (cnt == CNT_MAX);
  assign frame_done = last && (idx == 3'd5);
  assign din_ready  = ~pend;
  assign xfer       = din_valid && !pend;
  assign swap       = frame_done && pend;

  // sel/seg are computed from the post-edge idx and disp so they move together with idx,
  // and the first digit after a swap already shows the new value.
  always_comb begin
    idx_nxt      = idx;
    disp_dat_nxt = disp_dat;
    disp_dp_nxt  = disp_dp;
    if (last) begin
      idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
    if (swap) begin
      disp_dat_nxt = shd_dat;
      disp_dp_nxt  = shd_dp;
    end
    nib = disp_dat_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef SEG_BLANK_LEADING_ZERO_EN
    blank = (idx_nxt != 3'd0) && ((disp_dat_nxt >> {idx_nxt, 2'b00}) == 24'h0);
`else
    blank = 1'b0;
`endif
    sel_nxt = 6'b000001 << idx_nxt;
    seg_nxt = {~disp_dp_nxt[idx_nxt], blank ? 7'h7F : hex_decode(nib)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      idx      <= 3'd0;
      disp_dat <= 24'h0;
      disp_dp  <= 6'h0;
      shd_dat  <= 24'h0;
      shd_dp   <= 6'h0;
      pend     <= 1'b0;
      sel      <= 6'b000001;
      seg      <= 8'hC0;
    end else begin
      cnt      <= last ? '0 : cnt + 1'b1;
      idx      <= idx_nxt;
      disp_dat <= disp_dat_nxt;
      disp_dp  <= disp_dp_nxt;
      sel      <= sel_nxt;
      seg      <= seg_nxt;
      if (swap) begin
        pend <= 1'b0;
      end else if (xfer) begin
        pend    <= 1'b1;
        shd_dat <= din;
        shd_dp  <= dp_in;
      end
    end
  end

endmodule
